// File: rtl/sec_b2a_iter.sv
// sec_b2a_iter: area-folded masked Boolean-to-arithmetic converter.
//
// Converts an N_SHARES-share Boolean masking of a K_WIDTH-bit value x into an
// N_SHARES-share arithmetic masking. The sum of the arithmetic shares mod
// 2^K_WIDTH equals x. One ISW-masked Kogge-Stone adder is reused under an FSM.
// For each op = 0..N_SHARES-2 the adder computes z <- z + (-A_op). The shares
// A_i are drawn from i_rnd at accept. The final arithmetic share is the XOR of
// the refreshed z shares.
//
// Optional build macro:
//   SEC_B2A_RND_STALL_EN - when defined, any randomness-consuming cycle
//   (accept, REFR, GEN, ROUND, UNMASK) holds while i_rvld is low, and
//   o_rdy = IDLE & i_rvld. When undefined, i_rvld is ignored.
//
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   i_dvld/o_rdy   input handshake; i_b carries the Boolean shares
//   i_rnd/i_rvld   per-cycle randomness and its valid flag
//   o_rreq         i_rnd was consumed this cycle
//   o_a/o_dvld     arithmetic shares out; i_rdy is the downstream ready
//   o_state        current FSM state (debug)
//
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both high. An input is taken when i_dvld & o_rdy. An output is handed
// over when o_dvld & i_rdy. While o_dvld is high and i_rdy is low, o_a and
// o_dvld hold steady.
module sec_b2a_iter #(
  parameter int K_WIDTH  = 32,
  parameter int N_SHARES = 3,
  localparam int L  = $clog2(K_WIDTH),
  localparam int RW = K_WIDTH * N_SHARES * (N_SHARES - 1)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          i_dvld,
  output logic                          o_rdy,
  input  logic [K_WIDTH*N_SHARES-1:0]   i_b,
  input  logic [RW-1:0]                 i_rnd,
  input  logic                          i_rvld,
  output logic                          o_rreq,
  output logic [K_WIDTH*N_SHARES-1:0]   o_a,
  output logic                          o_dvld,
  input  logic                          i_rdy,
  output logic [2:0]                    o_state
);

  localparam int NP  = N_SHARES * (N_SHARES - 1) / 2;
  localparam int OCW = $clog2(N_SHARES);
  localparam int RCW = (L > 1) ? $clog2(L) : 1;

  typedef logic [N_SHARES-1:0][K_WIDTH-1:0] shares_t;
  typedef enum logic [2:0] {
    S_IDLE, S_REFR, S_GEN, S_ROUND, S_SUM, S_UNMASK, S_DONE
  } state_e;

  // ISW multiplication. Pair (i,j), i<j, uses one fresh word taken from
  // word index 'base' upward.
  function automatic shares_t isw_and(input shares_t a, input shares_t b,
                                      input logic [RW-1:0] rnd, input int base);
    shares_t c;
    logic [K_WIDTH-1:0] r;
    int w;
    w = base;
    for (int i = 0; i < N_SHARES; i++) c[i] = a[i] & b[i];
    for (int i = 0; i < N_SHARES; i++) begin
      for (int j = i + 1; j < N_SHARES; j++) begin
        r = rnd[w*K_WIDTH +: K_WIDTH];
        c[i] = c[i] ^ r;
        // Bracketing keeps r applied before the cross terms are folded in.
        c[j] = c[j] ^ ((r ^ (a[i] & b[j])) ^ (a[j] & b[i]));
        w++;
      end
    end
    return c;
  endfunction

  // ISW refresh: word r_ij is XORed into shares i and j.
  function automatic shares_t isw_refresh(input shares_t a, input logic [RW-1:0] rnd);
    shares_t c;
    logic [K_WIDTH-1:0] r;
    int w;
    w = 0;
    c = a;
    for (int i = 0; i < N_SHARES; i++) begin
      for (int j = i + 1; j < N_SHARES; j++) begin
        r = rnd[w*K_WIDTH +: K_WIDTH];
        c[i] = c[i] ^ r;
        c[j] = c[j] ^ r;
        w++;
      end
    end
    return c;
  endfunction

  state_e state_q, state_d;
  logic [OCW-1:0] op_q, op_d;
  logic [RCW-1:0] rnd_cnt_q, rnd_cnt_d;
  shares_t z_q, z_d, y_q, y_d, g_q, g_d, p_q, p_d, p0_q, p0_d;
  logic [N_SHARES-2:0][K_WIDTH-1:0] a_q, a_d;

  shares_t y_init, g_sh, p_sh;
  logic [K_WIDTH-1:0] neg_a, z_xor;
  logic rnd_ok, rreq;

`ifdef SEC_B2A_RND_STALL_EN
  assign rnd_ok = i_rvld;
`else
  logic unused_rvld;
  assign unused_rvld = i_rvld;
  assign rnd_ok = 1'b1;
`endif

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    rnd_cnt_d = rnd_cnt_q;
    z_d       = z_q;
    y_d       = y_q;
    g_d       = g_q;
    p_d       = p_q;
    p0_d      = p0_q;
    a_d       = a_q;
    rreq      = 1'b0;
    neg_a     = '0;
    for (int i = 0; i < N_SHARES - 1; i++) begin
      if (op_q == OCW'(i)) neg_a = '0 - a_q[i];
    end
    // The operand is shared as (-A_op, 0, ..., 0) before it is refreshed.
    y_init    = '0;
    y_init[0] = neg_a;
    // Shifts are linear, so each share is shifted on its own (zero fill).
    for (int i = 0; i < N_SHARES; i++) begin
      g_sh[i] = g_q[i] << (1 << rnd_cnt_q);
      p_sh[i] = p_q[i] << (1 << rnd_cnt_q);
    end

    unique case (state_q)
      S_IDLE: begin
        if (i_dvld && rnd_ok) begin
          z_d     = i_b;
          a_d     = i_rnd[K_WIDTH*(N_SHARES-1)-1:0];
          op_d    = '0;
          rreq    = 1'b1;
          state_d = S_REFR;
        end
      end
      S_REFR: begin
        if (rnd_ok) begin
          y_d     = isw_refresh(y_init, i_rnd);
          rreq    = 1'b1;
          state_d = S_GEN;
        end
      end
      S_GEN: begin
        if (rnd_ok) begin
          g_d       = isw_and(z_q, y_q, i_rnd, 0);
          p_d       = z_q ^ y_q;
          p0_d      = z_q ^ y_q;
          rnd_cnt_d = '0;
          rreq      = 1'b1;
          state_d   = S_ROUND;
        end
      end
      S_ROUND: begin
        if (rnd_ok) begin
          // Both products read the old p. Generate and propagate stay
          // disjoint, so XOR stands in for OR.
          g_d  = g_q ^ isw_and(p_q, g_sh, i_rnd, 0);
          p_d  = isw_and(p_q, p_sh, i_rnd, NP);
          rreq = 1'b1;
          if (rnd_cnt_q == RCW'(L - 1)) begin
            rnd_cnt_d = '0;
            state_d   = S_SUM;
          end else begin
            rnd_cnt_d = rnd_cnt_q + 1'b1;
          end
        end
      end
      S_SUM: begin
        for (int i = 0; i < N_SHARES; i++) z_d[i] = p0_q[i] ^ (g_q[i] << 1);
        if (op_q == OCW'(N_SHARES - 2)) begin
          state_d = S_UNMASK;
        end else begin
          op_d    = op_q + 1'b1;
          state_d = S_REFR;
        end
      end
      S_UNMASK: begin
        if (rnd_ok) begin
          z_d     = isw_refresh(z_q, i_rnd);
          rreq    = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (i_rdy) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      rnd_cnt_q <= '0;
      z_q       <= '0;
      y_q       <= '0;
      g_q       <= '0;
      p_q       <= '0;
      p0_q      <= '0;
      a_q       <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      rnd_cnt_q <= rnd_cnt_d;
      z_q       <= z_d;
      y_q       <= y_d;
      g_q       <= g_d;
      p_q       <= p_d;
      p0_q      <= p0_d;
      a_q       <= a_d;
    end
  end

  // The last arithmetic share is the XOR of the refreshed z shares. That
  // refresh was registered in UNMASK, so the value is stable in DONE.
  always_comb begin
    z_xor = '0;
    for (int i = 0; i < N_SHARES; i++) z_xor = z_xor ^ z_q[i];
  end

  assign o_a     = {z_xor, a_q};
  assign o_rdy   = (state_q == S_IDLE) && rnd_ok;
  assign o_dvld  = (state_q == S_DONE);
  assign o_rreq  = rreq;
  assign o_state = state_q;

endmodule

// File: tb/tb_sec_b2a_iter.sv
module tb_sec_b2a_iter;
  localparam int K    = 32;
  localparam int N    = 3;
  localparam int L    = $clog2(K);
  localparam int RW   = K * N * (N - 1);
  localparam int LAT  = (N - 1) * (L + 3) + 2;
  localparam int NREQ = 2 + (N - 1) * (L + 2);
  localparam int KS   = 8;
  localparam int NS   = 2;
  localparam int LS   = $clog2(KS);
  localparam int RWS  = KS * NS * (NS - 1);
  localparam int LATS = (NS - 1) * (LS + 3) + 2;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          i_dvld, o_rdy, i_rvld, o_rreq, o_dvld, i_rdy;
  logic [K*N-1:0] i_b, o_a;
  logic [RW-1:0]  i_rnd;
  logic [2:0]     o_state;

  logic            s_i_dvld, s_o_rdy, s_o_rreq, s_o_dvld;
  logic [KS*NS-1:0] s_i_b, s_o_a;
  logic [RWS-1:0]   s_i_rnd;
  logic [2:0]       s_o_state;

  sec_b2a_iter #(.K_WIDTH(K), .N_SHARES(N)) dut (
    .clk_i(clk), .rst_i(rst), .i_dvld(i_dvld), .o_rdy(o_rdy), .i_b(i_b),
    .i_rnd(i_rnd), .i_rvld(i_rvld), .o_rreq(o_rreq), .o_a(o_a),
    .o_dvld(o_dvld), .i_rdy(i_rdy), .o_state(o_state)
  );

  sec_b2a_iter #(.K_WIDTH(KS), .N_SHARES(NS)) dut_s (
    .clk_i(clk), .rst_i(rst), .i_dvld(s_i_dvld), .o_rdy(s_o_rdy), .i_b(s_i_b),
    .i_rnd(s_i_rnd), .i_rvld(1'b1), .o_rreq(s_o_rreq), .o_a(s_o_a),
    .o_dvld(s_o_dvld), .i_rdy(1'b1), .o_state(s_o_state)
  );

  // scoreboard
  int n_cmp = 0;
  int n_err = 0;
  logic [K-1:0] exp_q[$];

  // reference helpers (plain arithmetic on the specification's rules)
  function automatic logic [RW-1:0] rand_rnd();
    logic [RW-1:0] r;
    for (int w = 0; w < RW / 32; w++) r[w*32 +: 32] = $urandom();
    return r;
  endfunction

  function automatic logic [K*N-1:0] bool_shares(input logic [K-1:0] x);
    logic [K*N-1:0] v;
    logic [K-1:0] acc;
    acc = x;
    for (int i = 0; i < N - 1; i++) begin
      v[i*K +: K] = $urandom();
      acc = acc ^ v[i*K +: K];
    end
    v[(N-1)*K +: K] = acc;
    return v;
  endfunction

  function automatic logic [K-1:0] arith_sum(input logic [K*N-1:0] v);
    logic [K-1:0] s;
    s = '0;
    for (int i = 0; i < N; i++) s = s + v[i*K +: K];
    return s;
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
    i_rnd   = rand_rnd();
    s_i_rnd = RWS'($urandom());
  endtask

  // Accepts x in the current cycle, then runs until o_dvld or the cycle
  // budget. lat counts cycles from the accept cycle to the first DONE cycle.
  // i_rvld is held low for lat in [st_start, st_start+st_len).
  task automatic convert(input logic [K-1:0] x, input int st_start, input int st_len,
                         output int lat, output logic [K*(N-1)-1:0] a_exp,
                         output int nreq, output int nreq_st);
    i_b    = bool_shares(x);
    i_dvld = 1'b1;
    i_rvld = 1'b1;
    #1;
    a_exp   = i_rnd[K*(N-1)-1:0];
    exp_q.push_back(x);
    nreq    = o_rreq ? 1 : 0;
    nreq_st = 0;
    tick();
    lat = 1;
    while (lat < 200) begin
      // Traffic on i_dvld/i_b while busy must be ignored.
      i_dvld = 1'($urandom_range(0, 1));
      i_b    = {$urandom(), $urandom(), $urandom()};
      i_rvld = !(lat >= st_start && lat < st_start + st_len);
      #1;
      if (o_dvld) break;
      if (o_rreq) begin
        nreq++;
        if (!i_rvld) nreq_st++;
      end
      tick();
      lat++;
    end
    i_dvld = 1'b0;
    i_rvld = 1'b1;
  endtask

  // tests
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_cmp++; if (o_rdy !== 1'b1) begin n_err++; $display("FAIL reset_rdy got=%b exp=1", o_rdy); end
    n_cmp++; if (o_dvld !== 1'b0) begin n_err++; $display("FAIL reset_dvld got=%b exp=0", o_dvld); end
    n_cmp++; if (o_rreq !== 1'b0) begin n_err++; $display("FAIL reset_rreq got=%b exp=0", o_rreq); end
    n_cmp++; if (o_a !== '0) begin n_err++; $display("FAIL reset_oa got=%h exp=0", o_a); end
    n_cmp++; if (s_o_a !== '0 || s_o_rdy !== 1'b1) begin n_err++; $display("FAIL reset_small got_oa=%h rdy=%b", s_o_a, s_o_rdy); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int lat, nreq, nst;
    logic [K*(N-1)-1:0] a_exp;
    logic [K-1:0] ex;
    i_rdy = 1'b1;
    convert(32'h12345678, 0, 0, lat, a_exp, nreq, nst);
    ex = exp_q.pop_front();
    n_cmp++; if (lat !== LAT) begin n_err++; $display("FAIL basic_latency got=%0d exp=%0d", lat, LAT); end
    n_cmp++; if (arith_sum(o_a) !== ex) begin n_err++; $display("FAIL basic_sum got=%h exp=%h", arith_sum(o_a), ex); end
    n_cmp++; if (o_a[K*(N-1)-1:0] !== a_exp) begin n_err++; $display("FAIL basic_a_words got=%h exp=%h", o_a[K*(N-1)-1:0], a_exp); end
    n_cmp++; if (nreq !== NREQ) begin n_err++; $display("FAIL basic_rreq_count got=%0d exp=%0d", nreq, NREQ); end
    tick();
    n_cmp++; if (o_rdy !== 1'b1 || o_dvld !== 1'b0) begin n_err++; $display("FAIL basic_back_idle got rdy=%b dvld=%b exp 1/0", o_rdy, o_dvld); end
  endtask

  task automatic test_back_to_back();
    int lat, nreq, nst;
    logic [K*(N-1)-1:0] a_exp;
    logic [K-1:0] ex;
    logic [K-1:0] xs [2];
    xs[0] = 32'hFFFFFFFF;
    xs[1] = 32'h00000000;
    i_rdy = 1'b1;
    for (int t = 0; t < 2; t++) begin
      n_cmp++; if (o_rdy !== 1'b1) begin n_err++; $display("FAIL b2b_rdy_%0d got=%b exp=1", t, o_rdy); end
      convert(xs[t], 0, 0, lat, a_exp, nreq, nst);
      ex = exp_q.pop_front();
      n_cmp++; if (lat !== LAT) begin n_err++; $display("FAIL b2b_latency_%0d got=%0d exp=%0d", t, lat, LAT); end
      n_cmp++; if (arith_sum(o_a) !== ex) begin n_err++; $display("FAIL b2b_sum_%0d got=%h exp=%h", t, arith_sum(o_a), ex); end
      n_cmp++; if (o_a[K*(N-1)-1:0] !== a_exp) begin n_err++; $display("FAIL b2b_a_words_%0d got=%h exp=%h", t, o_a[K*(N-1)-1:0], a_exp); end
      tick();
    end
  endtask

  task automatic test_hold();
    int lat, nreq, nst;
    logic [K*(N-1)-1:0] a_exp;
    logic [K*N-1:0] held;
    logic [K-1:0] ex;
    i_rdy = 1'b0;
    convert($urandom(), 0, 0, lat, a_exp, nreq, nst);
    ex = exp_q.pop_front();
    held = o_a;
    n_cmp++; if (arith_sum(o_a) !== ex) begin n_err++; $display("FAIL hold_sum got=%h exp=%h", arith_sum(o_a), ex); end
    for (int c = 0; c < 5; c++) begin
      tick();
      i_dvld = 1'b1;
      i_b    = bool_shares($urandom());
      #1;
      n_cmp++; if (o_dvld !== 1'b1 || o_rdy !== 1'b0) begin n_err++; $display("FAIL hold_flags_%0d got dvld=%b rdy=%b exp 1/0", c, o_dvld, o_rdy); end
      n_cmp++; if (o_a !== held) begin n_err++; $display("FAIL hold_oa_%0d got=%h exp=%h", c, o_a, held); end
    end
    i_dvld = 1'b0;
    i_rdy  = 1'b1;
    tick();
    n_cmp++; if (o_rdy !== 1'b1 || o_dvld !== 1'b0) begin n_err++; $display("FAIL hold_release got rdy=%b dvld=%b exp 1/0", o_rdy, o_dvld); end
  endtask

  task automatic test_reset_mid();
    int lat, nreq, nst;
    logic [K*(N-1)-1:0] a_exp;
    logic [K-1:0] ex;
    i_rdy  = 1'b1;
    i_b    = bool_shares($urandom());
    i_dvld = 1'b1;
    tick();
    i_dvld = 1'b0;
    repeat (6) tick();
    rst = 1'b1;
    #1;
    n_cmp++; if (o_dvld !== 1'b0 || o_rdy !== 1'b1) begin n_err++; $display("FAIL midreset_flags got dvld=%b rdy=%b exp 0/1", o_dvld, o_rdy); end
    n_cmp++; if (o_a !== '0) begin n_err++; $display("FAIL midreset_oa got=%h exp=0", o_a); end
    tick();
    rst = 1'b0;
    tick();
    n_cmp++; if (o_dvld !== 1'b0 || o_rdy !== 1'b1) begin n_err++; $display("FAIL midreset_after got dvld=%b rdy=%b exp 0/1", o_dvld, o_rdy); end
    convert(32'hA5A5A5A5, 0, 0, lat, a_exp, nreq, nst);
    ex = exp_q.pop_front();
    n_cmp++; if (lat !== LAT) begin n_err++; $display("FAIL midreset_latency got=%0d exp=%0d", lat, LAT); end
    n_cmp++; if (arith_sum(o_a) !== ex) begin n_err++; $display("FAIL midreset_sum got=%h exp=%h", arith_sum(o_a), ex); end
    tick();
  endtask

  task automatic test_stall();
    int lat, nreq, nst, exp_lat, exp_st;
    logic [K*(N-1)-1:0] a_exp;
    logic [K-1:0] ex;
    logic exp_rdy;
`ifdef SEC_B2A_RND_STALL_EN
    exp_lat = LAT + 3;
    exp_st  = 0;
    exp_rdy = 1'b0;
`else
    exp_lat = LAT;
    exp_st  = 3;
    exp_rdy = 1'b1;
`endif
    i_rdy  = 1'b1;
    i_rvld = 1'b0;
    #1;
    n_cmp++; if (o_rdy !== exp_rdy) begin n_err++; $display("FAIL stall_idle_rdy got=%b exp=%b", o_rdy, exp_rdy); end
    i_rvld = 1'b1;
    // lat 4..6 are ROUND cycles of the first addition.
    convert($urandom(), 4, 3, lat, a_exp, nreq, nst);
    ex = exp_q.pop_front();
    n_cmp++; if (lat !== exp_lat) begin n_err++; $display("FAIL stall_latency got=%0d exp=%0d", lat, exp_lat); end
    n_cmp++; if (nst !== exp_st) begin n_err++; $display("FAIL stall_rreq got=%0d exp=%0d", nst, exp_st); end
    n_cmp++; if (nreq !== NREQ) begin n_err++; $display("FAIL stall_rreq_total got=%0d exp=%0d", nreq, NREQ); end
    n_cmp++; if (arith_sum(o_a) !== ex) begin n_err++; $display("FAIL stall_sum got=%h exp=%h", arith_sum(o_a), ex); end
    tick();
  endtask

  task automatic test_random();
    int lat, nreq, nst, hold;
    logic [K*(N-1)-1:0] a_exp;
    logic [K-1:0] ex;
    for (int t = 0; t < 8; t++) begin
      hold  = $urandom_range(0, 3);
      i_rdy = (hold == 0);
      convert($urandom(), 0, 0, lat, a_exp, nreq, nst);
      ex = exp_q.pop_front();
      n_cmp++; if (lat !== LAT) begin n_err++; $display("FAIL rand_latency_%0d got=%0d exp=%0d", t, lat, LAT); end
      n_cmp++; if (arith_sum(o_a) !== ex) begin n_err++; $display("FAIL rand_sum_%0d got=%h exp=%h", t, arith_sum(o_a), ex); end
      n_cmp++; if (o_a[K*(N-1)-1:0] !== a_exp) begin n_err++; $display("FAIL rand_a_words_%0d got=%h exp=%h", t, o_a[K*(N-1)-1:0], a_exp); end
      repeat (hold) tick();
      #1;
      n_cmp++; if (o_dvld !== 1'b1) begin n_err++; $display("FAIL rand_held_dvld_%0d got=%b exp=1", t, o_dvld); end
      i_rdy = 1'b1;
      tick();
    end
  endtask

  task automatic test_small();
    int lat;
    logic [KS-1:0] x, b0, a0, s;
    for (int t = 0; t < 4; t++) begin
      x  = (t == 0) ? 8'h80 : KS'($urandom());
      b0 = KS'($urandom());
      s_i_b    = {x ^ b0, b0};
      s_i_dvld = 1'b1;
      #1;
      a0 = s_i_rnd[KS-1:0];
      n_cmp++; if (s_o_rdy !== 1'b1) begin n_err++; $display("FAIL small_rdy_%0d got=%b exp=1", t, s_o_rdy); end
      tick();
      s_i_dvld = 1'b0;
      lat = 1;
      while (lat < 100) begin
        #1;
        if (s_o_dvld) break;
        tick();
        lat++;
      end
      s = s_o_a[KS-1:0] + s_o_a[2*KS-1:KS];
      n_cmp++; if (lat !== LATS) begin n_err++; $display("FAIL small_latency_%0d got=%0d exp=%0d", t, lat, LATS); end
      n_cmp++; if (s !== x) begin n_err++; $display("FAIL small_sum_%0d got=%h exp=%h", t, s, x); end
      n_cmp++; if (s_o_a[KS-1:0] !== a0) begin n_err++; $display("FAIL small_a0_%0d got=%h exp=%h", t, s_o_a[KS-1:0], a0); end
      tick();
    end
  endtask

  initial begin
    rst      = 1'b1;
    i_dvld   = 1'b0;
    i_b      = '0;
    i_rnd    = rand_rnd();
    i_rvld   = 1'b1;
    i_rdy    = 1'b1;
    s_i_dvld = 1'b0;
    s_i_b    = '0;
    s_i_rnd  = RWS'($urandom());
    test_reset();
    test_basic();
    test_back_to_back();
    test_hold();
    test_reset_mid();
    test_stall();
    test_random();
    test_small();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
